memory_stage: RTL

//   Parametrised MEM stage of the 5-stage RISC-V pipeline, placed between EX/MEM and writeback.
//   It drives an external data memory over a req/ack handshake and builds byte enables and

---
 rtl/memory_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage -- MEM stage of a 5-stage RISC-V pipeline.
//
// Sits between the EX/MEM register and writeback. Drives an external data
// memory over a req/ack handshake, places store data and byte enables on the
// correct byte lanes, sign/zero-extends load data, flags misaligned or
// illegal accesses and aborts accesses that wait longer than TIMEOUT cycles.
// The MEM/WB register is built here and upstream is stalled while an access
// is outstanding.
//
// Parameters
//   XLEN     datapath width, 32 or 64
//   REG_W    destination register index width
//   TIMEOUT  maximum number of WAIT cycles before an access is aborted (>=1)
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   *_m inputs            EX/MEM register contents (held stable while stall_m=1)
//   stall_m               hold EX/MEM and earlier stages
//   dmem_*                data memory handshake (req/we/addr/wdata/be out, rdata/ack in)
//   valid_w .. result_src MEM/WB register contents
//   misaligned_w, fault_w MEM/WB exception flags
module memory_stage #(
    parameter int XLEN    = 64,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_m,
    input  logic [XLEN-1:0]     alu_result_m,
    input  logic [XLEN-1:0]     write_data_m,
    input  logic [REG_W-1:0]    rd_m,
    input  logic [XLEN-1:0]     next_instruction_m,
    input  logic [2:0]          funct3_m,
    input  logic                mem_read_m,
    input  logic                mem_write_m,
    input  logic                reg_write_m,
    input  logic [1:0]          result_src_m,
    output logic                stall_m,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_be,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_ack,
    output logic                valid_w,
    output logic [XLEN-1:0]     alu_result,
    output logic [REG_W-1:0]    rd,
    output logic [XLEN-1:0]     next_instruction,
    output logic [XLEN-1:0]     mem_data,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic                misaligned_w,
    output logic                fault_w
);

    localparam int NB       = XLEN / 8;
    localparam int OFFW     = $clog2(NB);
    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam bit IS_RV32  = (XLEN == 32);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [OFFW-1:0]    off;
    logic               is_mem;
    logic               misaligned;
    logic               illegal;
    logic               mem_op;
    logic               timeout_hit;
    logic               abort;
    logic               complete;
    logic [NB-1:0]      be_base;
    logic               sgn;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    ext8, ext16, ext32;
    logic [XLEN-1:0]    load_ext;

    assign off    = alu_result_m[OFFW-1:0];
    assign is_mem = valid_m & (mem_read_m | mem_write_m);

    // Alignment only depends on the low offset bits covered by the access size.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_m[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    end

    // funct3=111 has no meaning, stores have no unsigned variants, and RV32
    // has neither doubleword accesses nor LWU.
    assign illegal = (funct3_m == 3'b111)
                   | (mem_write_m & funct3_m[2])
                   | (IS_RV32 & ((funct3_m[1:0] == 2'b11) | (funct3_m == 3'b110)));

    assign mem_op = is_mem & ~misaligned & ~illegal;

    // An ack arriving in the timeout cycle wins over the abort.
    assign timeout_hit = (state_reg == WAIT) && (cnt_reg == CNT_W'(TIMEOUT));
    assign abort       = mem_op & timeout_hit & ~dmem_ack;

    // Gated by reset so the request drops immediately, not at the next edge.
    assign dmem_req = mem_op & ~abort & ~reset;
    assign stall_m  = dmem_req & ~dmem_ack;
    assign complete = dmem_req & dmem_ack;

    assign dmem_we    = mem_write_m;
    assign dmem_addr  = {alu_result_m[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign dmem_wdata = write_data_m << {off, 3'b000};

    always_comb begin
        be_base = '0;
        case (funct3_m[1:0])
            2'b00:   be_base = NB'(8'h01);
            2'b01:   be_base = NB'(8'h03);
            2'b10:   be_base = NB'(8'h0F);
            default: be_base = NB'(8'hFF);
        endcase
    end
    assign dmem_be = be_base << off;

    // Load data: bring the addressed lane down to bit 0, then extend.
    assign sgn     = ~funct3_m[2];
    assign shifted = dmem_rdata >> {off, 3'b000};
    assign ext8    = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
    assign ext16   = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};

    generate
        if (XLEN > 32) begin : g_ext32_wide
            assign ext32 = {{(XLEN-32){sgn & shifted[31]}}, shifted[31:0]};
        end else begin : g_ext32_full
            assign ext32 = shifted;
        end
    endgenerate

    always_comb begin
        load_ext = shifted;
        case (funct3_m[1:0])
            2'b00:   load_ext = ext8;
            2'b01:   load_ext = ext16;
            2'b10:   load_ext = ext32;
            default: load_ext = shifted;
        endcase
    end

    // Access FSM: IDLE covers zero-wait accesses, WAIT counts waited cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op & ~dmem_ack) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT: begin
                // Leaving on ack, abort, or a dropped request (defensive).
                if (dmem_ack | abort | ~mem_op) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // MEM/WB register: bubbles while stalled, otherwise loads the stage result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_w          <= 1'b0;
            alu_result       <= '0;
            rd               <= '0;
            next_instruction <= '0;
            mem_data         <= '0;
            reg_write        <= 1'b0;
            result_src       <= '0;
            misaligned_w     <= 1'b0;
            fault_w          <= 1'b0;
        end else if (stall_m) begin
            valid_w   <= 1'b0;
            reg_write <= 1'b0;
        end else begin
            valid_w          <= valid_m;
            alu_result       <= alu_result_m;
            rd               <= rd_m;
            next_instruction <= next_instruction_m;
            result_src       <= result_src_m;
            mem_data         <= (complete & mem_read_m) ? load_ext : '0;
            misaligned_w     <= is_mem & misaligned;
            fault_w          <= (is_mem & illegal) | abort;
            reg_write        <= reg_write_m & ~(is_mem & (misaligned | illegal)) & ~abort;
        end
    end

endmodule
